// File: rtl/enum_walk_pkg.sv
// enum_walk_pkg: shared types, constants and lookup helpers for the my_enum
// walker. my_enum encodings are one-hot and non-contiguous, so neighbours
// come from explicit case tables rather than arithmetic.
package enum_walk_pkg;

    localparam int unsigned ENUM_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef logic [ENUM_W-1:0] my_enum;

    localparam my_enum MY_A = 32'd1;
    localparam my_enum MY_B = 32'd2;
    localparam my_enum MY_C = 32'd4;
    localparam my_enum MY_D = 32'd8;

    localparam my_enum      ENUM_FIRST = MY_A;
    localparam my_enum      ENUM_LAST  = MY_D;
    localparam int unsigned ENUM_COUNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } walk_state_t;

    // One presented word plus its position markers within the walk.
    typedef struct packed {
        my_enum value;
        logic   first;
        logic   last;
    } beat_t;

    // Declaration-order successor; wraps like the enum next() method.
    function automatic my_enum enum_next(input my_enum cur);
        my_enum nxt;
        case (cur)
            MY_A:    nxt = MY_B;
            MY_B:    nxt = MY_C;
            MY_C:    nxt = MY_D;
            MY_D:    nxt = MY_A;
            default: nxt = ENUM_FIRST;
        endcase
        return nxt;
    endfunction

    // Declaration-order predecessor; wraps like the enum prev() method.
    function automatic my_enum enum_prev(input my_enum cur);
        my_enum prv;
        case (cur)
            MY_D:    prv = MY_C;
            MY_C:    prv = MY_B;
            MY_B:    prv = MY_A;
            MY_A:    prv = MY_D;
            default: prv = ENUM_LAST;
        endcase
        return prv;
    endfunction

endpackage

// File: rtl/enum_step.sv
// enum_step: combinational walk-direction lookup for the my_enum walker.
//   cur      - member currently presented
//   nxt_c    - following member in walk order, with its first/last markers
//   start_c  - the walk's starting member, with its first/last markers
// REVERSE=0 walks MY_A..MY_D via enum_next; REVERSE=1 walks MY_D..MY_A via
// enum_prev. An unrecognised cur maps to the starting member.
module enum_step
    import enum_walk_pkg::*;
#(
    parameter bit REVERSE = 1'b0
) (
    input  my_enum cur,
    output beat_t  nxt_c,
    output beat_t  start_c
);

    localparam my_enum WALK_FIRST = REVERSE ? ENUM_LAST  : ENUM_FIRST;
    localparam my_enum WALK_LAST  = REVERSE ? ENUM_FIRST : ENUM_LAST;

    my_enum nxt;

    // Neighbour lookup and position flags for the following member.
    always_comb begin
        nxt           = REVERSE ? enum_prev(cur) : enum_next(cur);
        nxt_c.value   = nxt;
        nxt_c.first   = (nxt == WALK_FIRST);
        nxt_c.last    = (nxt == WALK_LAST);
        start_c.value = WALK_FIRST;
        start_c.first = 1'b1;
        start_c.last  = (WALK_FIRST == WALK_LAST);
    end

endmodule

// File: rtl/enum_walk_src.sv
// enum_walk_src: valid/ready source that walks my_enum in declaration order
// (or reverse) and emits one member per accepted beat.
//   clk, rst             - clock, synchronous active-high reset
//   start, stop          - walk start (IDLE only) / early stop request (RUN only)
//   out_valid, out_ready - output handshake
//   out_value            - current member; out_first/out_last mark walk ends
//   busy                 - high while walking
//   done                 - one-cycle pulse after the final pass completes
//   pass_cnt             - completed passes, saturating at 255
// NUM_PASSES=0 walks forever; all outputs are registered.
module enum_walk_src
    import enum_walk_pkg::*;
#(
    parameter int unsigned NUM_PASSES = 1,
    parameter bit          REVERSE    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ENUM_W-1:0] out_value,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    walk_state_t      state_q, state_d;
    beat_t            beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_pend_q, stop_pend_d;

    beat_t            nxt_beat;
    beat_t            start_beat;
    logic             xfer;
    logic [CNT_W-1:0] cnt_inc;
    logic             pass_final;

    enum_step #(
        .REVERSE (REVERSE)
    ) u_step (
        .cur     (beat_q.value),
        .nxt_c   (nxt_beat),
        .start_c (start_beat)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '{value: MY_A, first: 1'b0, last: 1'b0};
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;

        xfer       = valid_q && out_ready;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Saturated count never matches NUM_PASSES > 255, so such a walk runs on.
        pass_final = (NUM_PASSES != 0) && (32'(cnt_inc) == NUM_PASSES);

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d     = ST_RUN;
                    beat_d      = start_beat;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (xfer) begin
                    if (beat_q.last) begin
                        cnt_d = cnt_inc;
                    end
                    if (stop_pend_q) begin
                        // Pending stop: the presented beat is done, leave quietly.
                        state_d     = ST_IDLE;
                        valid_d     = 1'b0;
                        stop_pend_d = 1'b0;
                    end else if (!beat_q.last) begin
                        beat_d = nxt_beat;
                    end else if (pass_final) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                    end else begin
                        beat_d = start_beat;
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b0;
                stop_pend_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b0;
                stop_pend_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign out_valid = valid_q;
    assign out_value = beat_q.value;
    assign out_first = beat_q.first;
    assign out_last  = beat_q.last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = cnt_q;

endmodule

// File: tb/tb_enum_walk_src.sv
// tb_enum_walk_src: scoreboard bench for enum_walk_src. Three instances cover
// forward single pass, reverse two passes and endless walking. Expected beats
// are queued when a walk is started and checked as each beat transfers.
module tb_enum_walk_src;

    typedef struct packed {
        logic [31:0] value;
        logic        first;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;

    logic        f_start, f_stop, f_valid, f_ready, f_first, f_last, f_busy, f_done;
    logic [31:0] f_value;
    logic [7:0]  f_cnt;
    logic        r_start, r_stop, r_valid, r_ready, r_first, r_last, r_busy, r_done;
    logic [31:0] r_value;
    logic [7:0]  r_cnt;
    logic        i_start, i_stop, i_valid, i_ready, i_first, i_last, i_busy, i_done;
    logic [31:0] i_value;
    logic [7:0]  i_cnt;

    int checks   = 0;
    int failures = 0;
    int beats_f  = 0;
    int beats_r  = 0;
    int beats_i  = 0;
    int dones_f  = 0;
    int dones_i  = 0;

    exp_t q_f[$];
    exp_t q_r[$];
    exp_t q_i[$];

    enum_walk_src #(.NUM_PASSES(1), .REVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst), .start(f_start), .stop(f_stop),
        .out_valid(f_valid), .out_ready(f_ready), .out_value(f_value),
        .out_first(f_first), .out_last(f_last), .busy(f_busy),
        .done(f_done), .pass_cnt(f_cnt)
    );

    enum_walk_src #(.NUM_PASSES(2), .REVERSE(1'b1)) u_rev (
        .clk(clk), .rst(rst), .start(r_start), .stop(r_stop),
        .out_valid(r_valid), .out_ready(r_ready), .out_value(r_value),
        .out_first(r_first), .out_last(r_last), .busy(r_busy),
        .done(r_done), .pass_cnt(r_cnt)
    );

    enum_walk_src #(.NUM_PASSES(0), .REVERSE(1'b0)) u_inf (
        .clk(clk), .rst(rst), .start(i_start), .stop(i_stop),
        .out_valid(i_valid), .out_ready(i_ready), .out_value(i_value),
        .out_first(i_first), .out_last(i_last), .busy(i_busy),
        .done(i_done), .pass_cnt(i_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue the first nbeats of a walk, computed from the declaration-order table.
    task automatic push_walk(input int sel, input bit rev, input int nbeats);
        logic [31:0] members [4];
        exp_t e;
        int   pos;
        members[0] = 32'd1;
        members[1] = 32'd2;
        members[2] = 32'd4;
        members[3] = 32'd8;
        for (int n = 0; n < nbeats; n++) begin
            pos     = n % 4;
            e.value = rev ? members[3 - pos] : members[pos];
            e.first = (pos == 0);
            e.last  = (pos == 3);
            case (sel)
                0:       q_f.push_back(e);
                1:       q_r.push_back(e);
                default: q_i.push_back(e);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitors and done counters, sampled mid-cycle.
    always @(negedge clk) begin : mon_f
        exp_t e;
        if (f_done) dones_f++;
        if (f_valid && f_ready) begin
            beats_f++;
            if (q_f.size() == 0) begin
                check("f_extra_beat", f_value, 32'hFFFF_FFFF);
            end else begin
                e = q_f.pop_front();
                check("f_value", f_value, e.value);
                check("f_first", 32'(f_first), 32'(e.first));
                check("f_last", 32'(f_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin : mon_r
        exp_t e;
        if (r_valid && r_ready) begin
            beats_r++;
            if (q_r.size() == 0) begin
                check("r_extra_beat", r_value, 32'hFFFF_FFFF);
            end else begin
                e = q_r.pop_front();
                check("r_value", r_value, e.value);
                check("r_first", 32'(r_first), 32'(e.first));
                check("r_last", 32'(r_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin : mon_i
        exp_t e;
        if (i_done) dones_i++;
        if (i_valid && i_ready) begin
            beats_i++;
            if (q_i.size() == 0) begin
                check("i_extra_beat", i_value, 32'hFFFF_FFFF);
            end else begin
                e = q_i.pop_front();
                check("i_value", i_value, e.value);
                check("i_first", 32'(i_first), 32'(e.first));
                check("i_last", 32'(i_last), 32'(e.last));
            end
        end
    end

    initial begin
        rst = 1'b1;
        f_start = 1'b0; f_stop = 1'b0; f_ready = 1'b0;
        r_start = 1'b0; r_stop = 1'b0; r_ready = 1'b0;
        i_start = 1'b0; i_stop = 1'b0; i_ready = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_valid", 32'(f_valid), 32'd0);
        check("rst_value", f_value, 32'd1);
        check("rst_first", 32'(f_first), 32'd0);
        check("rst_last", 32'(f_last), 32'd0);
        check("rst_busy", 32'(f_busy), 32'd0);
        check("rst_done", 32'(f_done), 32'd0);
        check("rst_cnt", 32'(f_cnt), 32'd0);
        check("rst_rev_value", r_value, 32'd1);
        rst = 1'b0;
        tick();

        // Forward single pass at full throughput.
        push_walk(0, 1'b0, 4);
        f_ready = 1'b1;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        check("fwd_lat_valid", 32'(f_valid), 32'd1);
        check("fwd_lat_value", f_value, 32'd1);
        check("fwd_busy", 32'(f_busy), 32'd1);
        tick(); tick(); tick(); tick();
        check("fwd_beats", 32'(beats_f), 32'd4);
        check("fwd_done", 32'(f_done), 32'd1);
        check("fwd_done_valid", 32'(f_valid), 32'd0);
        check("fwd_cnt", 32'(f_cnt), 32'd1);
        tick();
        check("fwd_done_pulse", 32'(f_done), 32'd0);
        check("fwd_idle_busy", 32'(f_busy), 32'd0);
        check("fwd_idle_cnt_hold", 32'(f_cnt), 32'd1);

        // Backpressure while 2 is presented.
        push_walk(0, 1'b0, 4);
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        check("bp_cnt_clear", 32'(f_cnt), 32'd0);
        tick();
        f_ready = 1'b0;
        check("bp_pres_value", f_value, 32'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_value", f_value, 32'd2);
            check("bp_hold_valid", 32'(f_valid), 32'd1);
        end
        f_ready = 1'b1;
        tick();
        check("bp_after_value", f_value, 32'd4);
        for (int k = 0; k < 20 && !f_done; k++) tick();
        check("bp_done", 32'(f_done), 32'd1);
        tick();

        // Early stop while 2 is held under backpressure.
        push_walk(0, 1'b0, 2);
        dones_f = 0;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        tick();
        f_ready = 1'b0;
        f_stop  = 1'b1;
        tick();
        f_stop = 1'b0;
        check("stop_hold_value", f_value, 32'd2);
        check("stop_hold_valid", 32'(f_valid), 32'd1);
        tick();
        check("stop_hold_value2", f_value, 32'd2);
        f_ready = 1'b1;
        tick();
        check("stop_idle_valid", 32'(f_valid), 32'd0);
        check("stop_idle_busy", 32'(f_busy), 32'd0);
        check("stop_cnt", 32'(f_cnt), 32'd0);
        tick(); tick();
        check("stop_no_done", 32'(dones_f), 32'd0);
        check("stop_still_idle", 32'(f_valid), 32'd0);

        // Reset mid-walk while 4 is presented.
        push_walk(0, 1'b0, 2);
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        tick(); tick();
        f_ready = 1'b0;
        check("mid_pres_value", f_value, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(f_valid), 32'd0);
        check("mid_rst_value", f_value, 32'd1);
        check("mid_rst_busy", 32'(f_busy), 32'd0);
        push_walk(0, 1'b0, 4);
        f_ready = 1'b1;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        check("restart_value", f_value, 32'd1);
        check("restart_cnt", 32'(f_cnt), 32'd0);
        for (int k = 0; k < 20 && !f_done; k++) tick();
        check("restart_done", 32'(f_done), 32'd1);
        check("restart_pass", 32'(f_cnt), 32'd1);

        // Reverse two passes, no bubble at the wrap.
        push_walk(1, 1'b1, 8);
        r_ready = 1'b1;
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
        check("rev_first_value", r_value, 32'd8);
        check("rev_first_flag", 32'(r_first), 32'd1);
        tick(); tick(); tick(); tick();
        check("rev_wrap_valid", 32'(r_valid), 32'd1);
        check("rev_wrap_value", r_value, 32'd8);
        check("rev_cnt1", 32'(r_cnt), 32'd1);
        tick(); tick(); tick(); tick();
        check("rev_beats", 32'(beats_r), 32'd8);
        check("rev_done", 32'(r_done), 32'd1);
        check("rev_cnt2", 32'(r_cnt), 32'd2);
        tick();

        // Endless walk: 300 passes, count saturates, done never fires.
        push_walk(2, 1'b0, 1200);
        i_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 1200; k++) tick();
        check("inf_beats", 32'(beats_i), 32'd1200);
        check("inf_cnt_sat", 32'(i_cnt), 32'd255);
        check("inf_busy", 32'(i_busy), 32'd1);
        check("inf_no_done", 32'(dones_i), 32'd0);
        check("inf_wrap_value", i_value, 32'd1);
        push_walk(2, 1'b0, 1);
        i_ready = 1'b0;
        i_stop  = 1'b1;
        tick();
        i_stop  = 1'b0;
        i_ready = 1'b1;
        tick();
        check("inf_stop_valid", 32'(i_valid), 32'd0);
        check("inf_stop_cnt", 32'(i_cnt), 32'd255);
        tick();

        check("q_f_drained", 32'(q_f.size()), 32'd0);
        check("q_r_drained", 32'(q_r.size()), 32'd0);
        check("q_i_drained", 32'(q_i.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
